// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU Wishbone slave adapter.
//   fpu_wb_state_t   : adapter state machine encoding
//   FPU_BASE_ADDR    : default base of the FPU register window
//   FPU_TIMEOUT_DATA : read data returned when a register access times out
package fpu_pkg;

  localparam logic [31:0] FPU_BASE_ADDR    = 32'h3000_0000;
  localparam logic [31:0] FPU_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    StIdle,
    StRmwRd,
    StAccess,
    StWait,
    StResp
  } fpu_wb_state_t;

endpackage

// File: rtl/fpu_wb_byte_merge.sv
// Byte-lane merge for partial writes.
//   i_sel    : byte selects, 1 = take the byte from i_wdata
//   i_wdata  : bus write data
//   i_rdata  : register read-back data
//   o_merged : merged word
module fpu_wb_byte_merge
  import fpu_pkg::*;
(
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_rdata;
    for (int b = 0; b < 4; b++) begin
      if (i_sel[b]) o_merged[8*b +: 8] = i_wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/fpu_wb_slave.sv
// Wishbone B4 classic slave adapter for the FPU register block.
// Turns each in-window bus cycle into a single-cycle register-block access,
// with read-modify-write for partial-byte writes and a registered bus ack.
// Optional WAIT-state timeout enabled by defining FPU_WB_TIMEOUT_EN.
// Ports:
//   clk, rst_l                    : clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i : Wishbone request
//   wbs_ack_o, wbs_dat_o          : registered Wishbone response
//   addr, wren, wrdata            : register-block access (addr = 0 when idle)
//   reg_ack, reg_rddata           : register-block combinational response
module fpu_wb_slave
  import fpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = FPU_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_FF00,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] addr,
  output logic        wren,
  output logic [31:0] wrdata,
  input  logic        reg_ack,
  input  logic [31:0] reg_rddata
);

  fpu_wb_state_t r_state, w_state_d;

  logic [31:0] r_adr, r_dat, r_merged, r_dat_o, w_dat_o_d, w_merged;
  logic [3:0]  r_sel;
  logic        r_we, r_ack, w_ack_d;
  logic        w_latch, w_rmw_cap, w_in_window, w_req;

  assign w_in_window = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  // The !r_ack gate keeps a strobe still held during RESP from being taken twice.
  assign w_req       = wbs_cyc_i & wbs_stb_i & w_in_window & ~r_ack;

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat_o;

  fpu_wb_byte_merge u_merge (
    .i_sel    (r_sel),
    .i_wdata  (r_dat),
    .i_rdata  (reg_rddata),
    .o_merged (w_merged)
  );

`ifdef FPU_WB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CntW-1:0] r_cnt, w_cnt_d;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^{TIMEOUT_CYCLES, FPU_TIMEOUT_DATA};
`endif

  always_comb begin
    w_state_d = r_state;
    w_ack_d   = 1'b0;
    w_dat_o_d = r_dat_o;
    w_latch   = 1'b0;
    w_rmw_cap = 1'b0;
    addr      = 32'h0;
    wren      = 1'b0;
    wrdata    = 32'h0;
`ifdef FPU_WB_TIMEOUT_EN
    w_cnt_d   = r_cnt;
`endif

    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (wbs_we_i && (wbs_sel_i == 4'h0)) begin
            // Nothing to write: respond without touching the register block.
            w_state_d = StResp;
            w_ack_d   = 1'b1;
            w_dat_o_d = 32'h0;
          end else if (wbs_we_i && (wbs_sel_i != 4'hF)) begin
            w_state_d = StRmwRd;
          end else begin
            w_state_d = StAccess;
          end
        end
      end
      StRmwRd: begin
        addr      = r_adr;
        w_rmw_cap = 1'b1;
        w_state_d = StAccess;
      end
      StAccess: begin
        addr   = r_adr;
        wren   = r_we;
        wrdata = !r_we ? 32'h0 : (r_sel == 4'hF) ? r_dat : r_merged;
        if (reg_ack) begin
          w_state_d = StResp;
          w_ack_d   = 1'b1;
          w_dat_o_d = r_we ? 32'h0 : reg_rddata;
        end else begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        addr = r_adr;
        if (reg_ack) begin
          w_state_d = StResp;
          w_ack_d   = 1'b1;
          w_dat_o_d = r_we ? 32'h0 : reg_rddata;
        end else begin
`ifdef FPU_WB_TIMEOUT_EN
          if (int'(r_cnt) + 1 >= int'(TIMEOUT_CYCLES)) begin
            w_state_d = StResp;
            w_ack_d   = 1'b1;
            w_dat_o_d = FPU_TIMEOUT_DATA;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
`endif
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Cycle dropped mid-transaction: abandon silently. A write already driven
    // in ACCESS this cycle still reaches the register block.
    if (!wbs_cyc_i && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_ack_d   = 1'b0;
      w_dat_o_d = r_dat_o;
    end

`ifdef FPU_WB_TIMEOUT_EN
    if (w_state_d == StAccess) w_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= StIdle;
      r_ack    <= 1'b0;
      r_dat_o  <= 32'h0;
      r_adr    <= 32'h0;
      r_we     <= 1'b0;
      r_sel    <= 4'h0;
      r_dat    <= 32'h0;
      r_merged <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_ack   <= w_ack_d;
      r_dat_o <= w_dat_o_d;
      if (w_latch) begin
        r_adr <= wbs_adr_i;
        r_we  <= wbs_we_i;
        r_sel <= wbs_sel_i;
        r_dat <= wbs_dat_i;
      end
      if (w_rmw_cap) r_merged <= w_merged;
    end
  end

`ifdef FPU_WB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_cnt <= '0;
    else        r_cnt <= w_cnt_d;
  end
`endif

endmodule

// File: tb/tb_fpu_wb_slave.sv
// Self-checking bench for fpu_wb_slave: directed cases plus randomized
// transactions checked against an array model of the register file.
module tb_fpu_wb_slave;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] wrdata;
  logic        reg_ack;
  logic [31:0] reg_rddata;

  always #5 clk = ~clk;

  fpu_wb_slave dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .addr       (addr),
    .wren       (wren),
    .wrdata     (wrdata),
    .reg_ack    (reg_ack),
    .reg_rddata (reg_rddata)
  );

  // Register-block model: 32 words at 0x3000_0000..0x3000_007C, rest unmapped.
  logic [31:0] mem      [32];
  logic [31:0] init_val [32];
  logic [31:0] ref_mem  [32];
  int          addr_age;
  int          stall_req = 0;
  logic        mapped;

  assign mapped     = (addr[31:7] == 25'h060_0000);
  assign reg_ack    = mapped && (addr_age >= stall_req);
  assign reg_rddata = mapped ? mem[addr[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val[i];
    end else if (wren && mapped) begin
      mem[addr[6:2]] <= wrdata;
    end
    addr_age <= (addr != 32'h0) ? addr_age + 1 : 0;
  end

  // Write-strobe monitor.
  int          wren_cnt = 0;
  int          n_consec = 0;
  logic        prev_wren = 1'b0;
  logic [31:0] wren_addr, wren_data;

  always @(negedge clk) begin
    if (wren) begin
      wren_cnt++;
      wren_addr = addr;
      wren_data = wrdata;
      if (prev_wren) n_consec++;
    end
    prev_wren = wren;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic [31:0] a, input logic we, input logic [3:0] sel,
                        input logic [31:0] d, input int max_cyc, output logic got,
                        output int lat, output logic [31:0] rd, output int nwren);
    int w0;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = a;    wbs_dat_i = d;
    w0 = wren_cnt;
    got = 1'b0; lat = 0; rd = 32'h0;
    @(posedge clk);
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        got = 1'b1; lat = i; rd = wbs_dat_o;
        break;
      end
      @(posedge clk);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    nwren = wren_cnt - w0;
  endtask

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  initial begin
    logic        got, bad;
    int          lat, nw, exp_lat, idx, s;
    logic [31:0] rd, a, d, exp_rd;
    logic [3:0]  sel;
    logic        we;

    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    for (int i = 0; i < 32; i++) init_val[i] = $urandom;
    init_val[3] = 32'h4040_0000;
    init_val[5] = 32'h1234_5678;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val[i];
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wren", {31'h0, wren}, 32'h0);
    check("rst_wrdata", wrdata, 32'h0);
    rst_l = 1'b1;

    // Full write.
    bus_op(32'h3000_0000, 1'b1, 4'hF, 32'h3F80_0000, 20, got, lat, rd, nw);
    ref_mem[0] = 32'h3F80_0000;
    check("fw_ack", {31'h0, got}, 32'h1);
    check("fw_lat", lat, 2);
    check("fw_nwren", nw, 1);
    check("fw_addr", wren_addr, 32'h3000_0000);
    check("fw_data", wren_data, 32'h3F80_0000);

    // Read.
    bus_op(32'h3000_000C, 1'b0, 4'hF, 32'h0, 20, got, lat, rd, nw);
    check("rd_lat", lat, 2);
    check("rd_data", rd, 32'h4040_0000);
    check("rd_nwren", nw, 0);

    // Partial write.
    d = {16'($urandom), 16'hABCD};
    bus_op(32'h3000_0014, 1'b1, 4'b0011, d, 20, got, lat, rd, nw);
    ref_mem[5] = 32'h1234_ABCD;
    check("pw_lat", lat, 3);
    check("pw_nwren", nw, 1);
    check("pw_data", wren_data, 32'h1234_ABCD);
    check("pw_rd", rd, 32'h0);

    // Out-of-window access.
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_1000;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wbs_ack_o || (addr != 32'h0)) bad = 1'b1;
    end
    check("oow_quiet", {31'h0, bad}, 32'h0);
    wbs_cyc_i = 0; wbs_stb_i = 0;

    // Unmapped in-window address: no register ack.
`ifdef FPU_WB_TIMEOUT_EN
    bus_op(32'h3000_00F0, 1'b0, 4'hF, 32'h0, 400, got, lat, rd, nw);
    check("to_lat", lat, 257);
    check("to_data", rd, 32'hDEAD_BEEF);
`else
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_00F0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (wbs_ack_o) bad = 1'b1;
    end
    check("um_noack", {31'h0, bad}, 32'h0);
    check("um_addr", addr, 32'h3000_00F0);
    @(posedge clk); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge clk); @(negedge clk);
    check("um_abort_addr", addr, 32'h0);
    check("um_abort_ack", {31'h0, wbs_ack_o}, 32'h0);
`endif

    // Read to load a nonzero response, then reset in the middle of WAIT.
    bus_op(32'h3000_000C, 1'b0, 4'hF, 32'h0, 20, got, lat, rd, nw);
    check("pre_rst_rd", rd, 32'h4040_0000);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_00F8;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("wait_addr", addr, 32'h3000_00F8);
    #2 rst_l = 1'b0;
    #1;
    check("arst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("arst_dat", wbs_dat_o, 32'h0);
    check("arst_addr", addr, 32'h0);
    check("arst_wren", {31'h0, wren}, 32'h0);
    check("arst_wrdata", wrdata, 32'h0);
    #1 rst_l = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    bus_op(32'h3000_0000, 1'b0, 4'hF, 32'h0, 20, got, lat, rd, nw);
    check("post_rst_lat", lat, 2);
    check("post_rst_rd", rd, ref_mem[0]);

    // Randomized transactions, sometimes with a slow register block.
    for (int t = 0; t < 60; t++) begin
      idx = int'($urandom_range(0, 31));
      we  = 1'($urandom);
      sel = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sel = 4'hF;
      d   = $urandom;
      s   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      stall_req = s;
      a = 32'h3000_0000 + 32'(idx * 4);
      if (we && sel == 4'h0)      exp_lat = 1;
      else if (we && sel != 4'hF) exp_lat = (s + 2 > 3) ? s + 2 : 3;
      else                        exp_lat = 2 + s;
      exp_rd = we ? 32'h0 : ref_mem[idx];
      bus_op(a, we, sel, d, 20, got, lat, rd, nw);
      check("rnd_lat", lat, exp_lat);
      check("rnd_rd", rd, exp_rd);
      check("rnd_nwren", nw, (we && sel != 4'h0) ? 1 : 0);
      if (we && sel != 4'h0) begin
        ref_mem[idx] = merge_ref(ref_mem[idx], d, sel);
        check("rnd_wdata", wren_data, ref_mem[idx]);
        check("rnd_waddr", wren_addr, a);
      end
      stall_req = 0;
    end

    // Final sweep of the register file.
    for (int i = 0; i < 32; i++) begin
      bus_op(32'h3000_0000 + 32'(i * 4), 1'b0, 4'hF, 32'h0, 20, got, lat, rd, nw);
      check("sweep_rd", rd, ref_mem[i]);
    end
    check("wren_consecutive", n_consec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
